// File: rtl/tlight_pkg.sv
// Shared types, lamp codes and phase sequencing for the traffic-light monitor.
package tlight_pkg;

   localparam int unsigned LAMP_W = 3;
   localparam int unsigned CYC_W  = 16;

   typedef enum logic [1:0] {
      PH_G  = 2'd0,
      PH_A  = 2'd1,
      PH_R  = 2'd2,
      PH_RA = 2'd3
   } phase_t;

   typedef enum logic [1:0] {
      FLT_NONE    = 2'd0,
      FLT_ILLEGAL = 2'd1,
      FLT_TRANS   = 2'd2,
      FLT_TIMEOUT = 2'd3
   } fault_t;

   // {r,a,g} encodings of the legal lamp codes
   localparam logic [LAMP_W-1:0] LAMP_G  = 3'b001;
   localparam logic [LAMP_W-1:0] LAMP_A  = 3'b010;
   localparam logic [LAMP_W-1:0] LAMP_R  = 3'b100;
   localparam logic [LAMP_W-1:0] LAMP_RA = 3'b110;

   function automatic phase_t next_phase(input phase_t p);
      phase_t n;
      case (p)
         PH_G:    n = PH_A;
         PH_A:    n = PH_R;
         PH_R:    n = PH_RA;
         default: n = PH_G;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/tlight_lamp_decode.sv
// Combinational lamp-code decoder: {r,a,g} -> legal flag and phase.
module tlight_lamp_decode
   import tlight_pkg::*;
(
   input  logic [LAMP_W-1:0] code,
   output logic              legal_c,
   output phase_t            phase_c
);

   always_comb begin
      legal_c = 1'b0;
      phase_c = PH_G;
      case (code)
         LAMP_G:  begin legal_c = 1'b1; phase_c = PH_G;  end
         LAMP_A:  begin legal_c = 1'b1; phase_c = PH_A;  end
         LAMP_R:  begin legal_c = 1'b1; phase_c = PH_R;  end
         LAMP_RA: begin legal_c = 1'b1; phase_c = PH_RA; end
         default: begin legal_c = 1'b0; phase_c = PH_G;  end
      endcase
   end

endmodule

// File: rtl/tlight_monitor.sv
// Traffic-light sequence monitor: tracks phase, dwell and completed cycles, latches the first fault.
module tlight_monitor
   import tlight_pkg::*;
#(
   parameter int unsigned MAX_DWELL = 255,
   parameter int unsigned CNT_W     = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             r,
   input  logic             a,
   input  logic             g,
   input  logic             fault_clr,
   output logic [1:0]       phase,
   output logic             phase_valid,
   output logic [CNT_W-1:0] dwell,
   output logic [CYC_W-1:0] cycles_done,
   output logic             fault,
   output logic [1:0]       fault_code
);

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(MAX_DWELL);
   localparam logic [CYC_W-1:0] CYC_MAX   = '1;

   state_t            state;
   logic [LAMP_W-1:0] sample;
   phase_t            phase_q;
   fault_t            fcode_q;
   logic              s_legal_c;
   phase_t            s_phase_c;

   tlight_lamp_decode u_decode (
      .code    (sample),
      .legal_c (s_legal_c),
      .phase_c (s_phase_c)
   );

   assign phase      = phase_q;
   assign fault_code = fcode_q;

   // The FSM only ever looks at the registered sample, never the raw lamps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample      <= '0;
         state       <= ST_SYNC;
         phase_q     <= PH_G;
         phase_valid <= 1'b0;
         dwell       <= '0;
         cycles_done <= '0;
         fault       <= 1'b0;
         fcode_q     <= FLT_NONE;
      end else begin
         sample <= {r, a, g};
         case (state)
            ST_SYNC: begin
               if (s_legal_c) begin
                  phase_q     <= s_phase_c;
                  dwell       <= '0;
                  phase_valid <= 1'b1;
                  state       <= ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (!s_legal_c) begin
                  fcode_q     <= FLT_ILLEGAL;
                  fault       <= 1'b1;
                  phase_valid <= 1'b0;
                  state       <= ST_FAULT;
               end else if (s_phase_c == phase_q) begin
                  if (dwell == DWELL_MAX) begin
                     fcode_q     <= FLT_TIMEOUT;
                     fault       <= 1'b1;
                     phase_valid <= 1'b0;
                     state       <= ST_FAULT;
                  end else begin
                     dwell <= dwell + CNT_W'(1);
                  end
               end else if (s_phase_c == next_phase(phase_q)) begin
                  phase_q <= s_phase_c;
                  dwell   <= '0;
                  if (phase_q == PH_RA && cycles_done != CYC_MAX) begin
                     cycles_done <= cycles_done + CYC_W'(1);
                  end
               end else begin
                  fcode_q     <= FLT_TRANS;
                  fault       <= 1'b1;
                  phase_valid <= 1'b0;
                  state       <= ST_FAULT;
               end
            end
            ST_FAULT: begin
               // Everything stays frozen until software acknowledges the fault.
               if (fault_clr) begin
                  fault   <= 1'b0;
                  fcode_q <= FLT_NONE;
                  state   <= ST_SYNC;
               end
            end
            default: begin
               state <= ST_SYNC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tlight_monitor.sv
// Randomized and directed bench for tlight_monitor against a behavioural sequence model.
module tb_tlight_monitor;

   localparam int unsigned MAXD  = 4;
   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             r, a, g, fault_clr;
   logic [1:0]       phase;
   logic             phase_valid;
   logic [CNT_W-1:0] dwell;
   logic [15:0]      cycles_done;
   logic             fault;
   logic [1:0]       fault_code;

   int checks   = 0;
   int failures = 0;

   // model: mode 0 = waiting for a legal code, 1 = tracking, 2 = faulted
   int          m_mode, m_phase, m_dwell, m_cycles, m_code;
   logic [2:0]  m_samp;
   logic [2:0]  codes [4];
   logic [2:0]  last_code;

   tlight_monitor #(.MAX_DWELL(MAXD), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .r           (r),
      .a           (a),
      .g           (g),
      .fault_clr   (fault_clr),
      .phase       (phase),
      .phase_valid (phase_valid),
      .dwell       (dwell),
      .cycles_done (cycles_done),
      .fault       (fault),
      .fault_code  (fault_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int code_phase(input logic [2:0] c);
      for (int i = 0; i < 4; i++) if (codes[i] == c) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_phase = 0; m_dwell = 0; m_cycles = 0; m_code = 0; m_samp = 3'b000;
   endtask

   task automatic model_fault(input int c);
      m_mode = 2;
      m_code = c;
   endtask

   // One rising edge: act on the previously sampled code, then capture the new one.
   task automatic model_edge(input logic [2:0] code, input logic clr);
      int p;
      p = code_phase(m_samp);
      if (m_mode == 2) begin
         if (clr) begin m_mode = 0; m_code = 0; end
      end else if (m_mode == 0) begin
         if (p >= 0) begin m_phase = p; m_dwell = 0; m_mode = 1; end
      end else begin
         if (p < 0) model_fault(1);
         else if (p == m_phase) begin
            if (m_dwell == int'(MAXD)) model_fault(3);
            else m_dwell++;
         end else if (p == (m_phase + 1) % 4) begin
            if (m_phase == 3 && m_cycles < 65535) m_cycles++;
            m_phase = p;
            m_dwell = 0;
         end else model_fault(2);
      end
      m_samp = code;
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".phase"},  phase,       m_phase);
      check({tag, ".valid"},  phase_valid, (m_mode == 1) ? 1 : 0);
      check({tag, ".dwell"},  dwell,       m_dwell);
      check({tag, ".cycles"}, cycles_done, m_cycles);
      check({tag, ".fault"},  fault,       (m_mode == 2) ? 1 : 0);
      check({tag, ".code"},   fault_code,  m_code);
   endtask

   task automatic step(input logic [2:0] code, input logic clr);
      @(negedge clk);
      {r, a, g} = code;
      fault_clr = clr;
      last_code = code;
      @(posedge clk);
      model_edge(code, clr);
      #1;
      compare_all("step");
   endtask

   // Reset pulled mid-cycle; outputs must clear without waiting for an edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all("rst");
      @(negedge clk);
      {r, a, g} = 3'b000;
      fault_clr = 1'b0;
      last_code = 3'b000;
      rst_n = 1'b1;
   endtask

   initial begin
      int sel;
      int p;
      codes[0] = 3'b001; codes[1] = 3'b010; codes[2] = 3'b100; codes[3] = 3'b110;
      rst_n = 1'b0; {r, a, g} = 3'b000; fault_clr = 1'b0; last_code = 3'b000;
      model_reset();
      #1;
      compare_all("por");
      @(negedge clk);
      rst_n = 1'b1;

      // all-dark lamps after reset never sync and never fault
      for (int i = 0; i < 10; i++) step(3'b000, 1'b0);
      check("dark.fault", fault, 0);
      check("dark.valid", phase_valid, 0);
      step(3'b010, 1'b0);
      step(3'b010, 1'b0);
      check("sync_a.phase", phase, 1);
      check("sync_a.valid", phase_valid, 1);

      // eight full sequences plus the closing G
      do_reset();
      for (int s = 0; s < 8; s++) for (int k = 0; k < 4; k++) step(codes[k], 1'b0);
      step(3'b001, 1'b0);
      step(3'b001, 1'b0);
      check("seq8.cycles", cycles_done, 8);
      check("seq8.valid", phase_valid, 1);
      check("seq8.fault", fault, 0);

      // three sequences, then reset mid-sequence and stray clears
      do_reset();
      for (int s = 0; s < 3; s++) for (int k = 0; k < 4; k++) step(codes[k], 1'b0);
      step(3'b001, 1'b0);
      step(3'b001, 1'b0);
      check("seq3.cycles", cycles_done, 3);
      step(3'b010, 1'b0);
      do_reset();
      check("rst3.cycles", cycles_done, 0);
      step(3'b000, 1'b1);
      step(3'b001, 1'b1);
      step(3'b001, 1'b1);
      step(3'b010, 1'b1);
      step(3'b010, 1'b0);
      check("clr_ign.fault", fault, 0);
      check("clr_ign.phase", phase, 1);

      // dwell boundary: five samples of red is fine
      do_reset();
      for (int i = 0; i < 5; i++) step(3'b100, 1'b0);
      step(3'b110, 1'b0);
      check("dwell5.dwell", dwell, 4);
      check("dwell5.fault", fault, 0);

      // six samples of red times out
      do_reset();
      for (int i = 0; i < 6; i++) step(3'b100, 1'b0);
      step(3'b110, 1'b0);
      check("dwell6.fault", fault, 1);
      check("dwell6.code", fault_code, 3);
      check("dwell6.dwell", dwell, 4);

      // illegal code while tracking, then clear and resync on G
      do_reset();
      step(3'b001, 1'b0); step(3'b001, 1'b0);
      step(3'b011, 1'b0); step(3'b011, 1'b0);
      check("illegal.code", fault_code, 1);
      step(3'b011, 1'b1);
      check("clr.fault", fault, 0);
      check("clr.valid", phase_valid, 0);
      step(3'b001, 1'b0); step(3'b001, 1'b0);
      check("resync.phase", phase, 0);
      check("resync.valid", phase_valid, 1);

      // G straight to R is a bad transition; later illegal codes cannot overwrite it
      do_reset();
      step(3'b001, 1'b0); step(3'b001, 1'b0);
      step(3'b100, 1'b0); step(3'b100, 1'b0);
      check("trans.code", fault_code, 2);
      for (int i = 0; i < 3; i++) step(3'b111, 1'b0);
      check("trans_hold.code", fault_code, 2);
      check("trans_hold.fault", fault, 1);

      // randomized traffic: mostly legal sequencing with holds, glitches, clears and resets
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         sel = int'($urandom_range(0, 99));
         if (sel == 0) begin
            do_reset();
         end else begin
            p = code_phase(last_code);
            if (sel < 60)
               step((p >= 0) ? codes[(p + 1) % 4] : codes[$urandom_range(0, 3)],
                    ($urandom_range(0, 9) == 0));
            else if (sel < 92)
               step(last_code, ($urandom_range(0, 9) == 0));
            else
               step(3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tlight_monitor.md
TLIGHT_MONITOR -- requirements
Module: tlight_monitor

Interface
REQ-001 Parameter MAX_DWELL, default 255: maximum number of extra consecutive samples a lamp code may hold before a timeout fault.
REQ-002 Parameter CNT_W, default 8: width of the dwell counter; SHALL satisfy 2**CNT_W > MAX_DWELL.
REQ-003 Port clk, input, 1: single clock; all state changes occur on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port r, input, 1: red lamp from the traffic-light controller.
REQ-006 Port a, input, 1: amber lamp.
REQ-007 Port g, input, 1: green lamp.
REQ-008 Port fault_clr, input, 1: single-cycle request to clear a latched fault.
REQ-009 Port phase, output, 2: decoded phase (0=G, 1=A, 2=R, 3=RA).
REQ-010 Port phase_valid, output, 1: phase is tracked and trusted.
REQ-011 Port dwell, output, CNT_W: extra samples spent in the current phase.
REQ-012 Port cycles_done, output, 16: number of completed RA->G transitions.
REQ-013 Port fault, output, 1: sticky fault flag.
REQ-014 Port fault_code, output, 2: 0=none, 1=illegal lamp code, 2=illegal transition, 3=dwell timeout.

Function
REQ-015 {r,a,g} SHALL be registered into a sample register every cycle; the FSM acts only on this sample, and all outputs are registered, giving 2-cycle latency from a lamp change to the corresponding output change.
REQ-016 Legal codes: 001=G, 010=A, 100=R, 110=RA; codes 000, 011, 101 and 111 are illegal.
REQ-017 Legal successors: G->A, A->R, R->RA, RA->G; a repeated sample of the same code is a hold.
REQ-018 FSM states: SYNC, TRACK and FAULT.
REQ-019 SYNC: phase_valid=0; a legal sample loads phase, clears dwell, sets phase_valid=1 and moves to TRACK; an illegal sample leaves the FSM in SYNC and raises no fault.
REQ-020 TRACK hold: dwell increments by 1; a hold sampled while dwell==MAX_DWELL sets fault_code=3, dwell stays at MAX_DWELL, and the FSM moves to FAULT.
REQ-021 TRACK legal successor: phase updates and dwell clears to 0; on RA->G, cycles_done increments, saturating at 16'hFFFF.
REQ-022 TRACK illegal code: fault_code=1 and the FSM moves to FAULT. TRACK legal code that is not the successor: fault_code=2 and the FSM moves to FAULT.
REQ-023 Fault priority, if causes coincide: code 1 > code 2 > code 3.
REQ-024 FAULT: fault=1, phase_valid=0, phase/dwell/cycles_done/fault_code frozen; the first fault wins and later events are ignored.
REQ-025 fault_clr in FAULT: next cycle the FSM is in SYNC with fault=0 and fault_code=0; cycles_done is kept.
REQ-026 fault_clr in SYNC or TRACK SHALL be ignored.

Reset
REQ-027 rst_n low SHALL immediately set: sample=000, FSM=SYNC, phase=0, phase_valid=0, dwell=0, cycles_done=0, fault=0, fault_code=0.
REQ-028 Reset asserted mid-cycle or mid-fault SHALL override all other activity; after release, the block behaves as from power-up.

Structure
REQ-029 Package tlight_pkg SHALL hold:
- phase_t enum (PH_G, PH_A, PH_R, PH_RA)
- lamp code constants
- fault_t enum
- next_phase() function
REQ-030 Sub-module tlight_lamp_decode SHALL be purely combinational: 3-bit code -> {legal, phase_t}. The FSM, counters and registers SHALL live in tlight_monitor.

Verification
REQ-031 Drive 001,010,100,110 repeated, one code per cycle, for 8 full sequences -> phase_valid=1, fault=0, cycles_done=8.
REQ-032 With MAX_DWELL=4, hold 100 for 5 samples -> no fault, dwell=4. Hold for 6 samples -> fault=1, fault_code=3.
REQ-033 In TRACK, drive 011 -> fault_code=1 two cycles later. Then pulse fault_clr -> SYNC, fault=0. Then drive 001 -> phase=0, phase_valid=1.
REQ-034 In TRACK at G, drive 100 -> fault_code=2. Then drive 111 while in FAULT -> fault_code stays 2.
REQ-035 Start with 000 for 10 cycles after reset -> no fault, phase_valid=0. Then drive 010 -> phase=1, phase_valid=1.
REQ-036 Assert rst_n low mid-sequence with cycles_done=3 -> all outputs zero immediately. Pulse fault_clr outside FAULT -> no effect.
